// File: rtl/tcdm_varlat_bank_arb.sv
// rtl/tcdm_varlat_bank_arb.sv - round-robin bank arbiter with in-order variable-latency response routing
//
// Purpose:
//   Arbitrates NumIn master ports onto one memory bank. Each accepted request's
//   master index is queued in an in-order ID FIFO of depth MaxOutstanding. Each
//   bank response is routed back to the master at the FIFO head.
//
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   req_i/gnt_o    per-master request and grant (NumIn bits)
//   data_i         per-master request payload, master k at [k*ReqDataWidth +: ReqDataWidth]
//   vld_o          per-master response valid (one-hot or zero)
//   rdata_o        bank rdata broadcast to every master, NumIn copies
//   req_o/gnt_i    request/grant toward the bank
//   data_o         payload of the winning master
//   vld_i/rdata_i  in-order bank response
//   spurious_o     response arrived with nothing outstanding

module tcdm_varlat_bank_arb #(
    parameter int NumIn          = 4,
    parameter int ReqDataWidth   = 32,
    parameter int RespDataWidth  = 32,
    parameter int MaxOutstanding = 2,
    parameter int LogNumIn       = (NumIn > 1 ? $clog2(NumIn) : 1)
) (
    input  logic                              clk_i,
    input  logic                              rst_ni,
    input  logic [NumIn-1:0]                  req_i,
    output logic [NumIn-1:0]                  gnt_o,
    input  logic [NumIn*ReqDataWidth-1:0]     data_i,
    output logic [NumIn-1:0]                  vld_o,
    output logic [NumIn*RespDataWidth-1:0]    rdata_o,
    output logic                              req_o,
    input  logic                              gnt_i,
    output logic [ReqDataWidth-1:0]           data_o,
    input  logic                              vld_i,
    input  logic [RespDataWidth-1:0]          rdata_i,
    output logic                              spurious_o
);

    localparam int PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0]     LastPtr = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0]     MaxCnt  = CntW'(MaxOutstanding);
    localparam logic [LogNumIn-1:0] LastIn  = LogNumIn'(NumIn - 1);

    logic [LogNumIn-1:0] rr_q;
    logic [LogNumIn-1:0] fifo_q [MaxOutstanding];
    logic [PtrW-1:0]     rd_ptr_q, wr_ptr_q;
    logic [CntW-1:0]     count_q;

    logic [LogNumIn-1:0] winner;
    logic                full, push, pop;
    int unsigned         idx;

    // First requester at or after rr_q, scanning upward modulo NumIn.
    always_comb begin
        winner = '0;
        idx    = 0;
        for (int i = NumIn - 1; i >= 0; i--) begin
            idx = int'(rr_q) + i;
            if (idx >= NumIn) begin
                idx = idx - NumIn;
            end
            // Scanning downward so the lowest offset is the last to write.
            if (req_i[idx]) begin
                winner = idx[LogNumIn-1:0];
            end
        end
    end

    // The full check uses only registered count, keeping vld_i off the request path.
    assign full       = (count_q == MaxCnt);
    assign req_o      = (|req_i) && !full;
    assign push       = req_o && gnt_i;
    assign pop        = vld_i && (count_q != '0);
    assign spurious_o = vld_i && (count_q == '0);
    assign data_o     = data_i[int'(winner)*ReqDataWidth +: ReqDataWidth];
    assign rdata_o    = {NumIn{rdata_i}};

    always_comb begin
        gnt_o = '0;
        vld_o = '0;
        gnt_o[winner]           = push;
        vld_o[fifo_q[rd_ptr_q]] = pop;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q     <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < MaxOutstanding; i++) begin
                fifo_q[i] <= '0;
            end
        end else begin
            if (push) begin
                rr_q             <= (winner == LastIn) ? '0 : winner + 1'b1;
                fifo_q[wr_ptr_q] <= winner;
                wr_ptr_q         <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_tcdm_varlat_bank_arb.sv
// tb/tb_tcdm_varlat_bank_arb.sv - scoreboard bench for tcdm_varlat_bank_arb
module tb_tcdm_varlat_bank_arb;

    localparam int N = 4;
    localparam int M = 2;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic [N-1:0]     req_i, gnt_o, vld_o;
    logic [N*W-1:0]   data_i, rdata_o;
    logic             req_o, gnt_i, vld_i, spurious_o;
    logic [W-1:0]     data_o, rdata_i;

    always #5 clk = ~clk;

    tcdm_varlat_bank_arb #(
        .NumIn(N), .ReqDataWidth(W), .RespDataWidth(W), .MaxOutstanding(M)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
        .data_i(data_i), .vld_o(vld_o), .rdata_o(rdata_o), .req_o(req_o),
        .gnt_i(gnt_i), .data_o(data_o), .vld_i(vld_i), .rdata_i(rdata_i),
        .spurious_o(spurious_o)
    );

    typedef struct {
        logic         req;
        logic [N-1:0] gnt;
        logic [W-1:0] data;
        logic [N-1:0] vld;
        logic         spur;
        logic [W-1:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   idq[$];
    int   rr_m = 0;
    int   vectors = 0;
    int   miscompares = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, predict the outputs from the reference model,
    // then advance the model as if the clock edge had occurred.
    task automatic step(input logic [N-1:0] req, input logic g, input logic v,
                        input logic rst, input logic [W-1:0] rd);
        exp_t e;
        int   w;
        @(posedge clk);
        #1;
        rst_ni  = rst;
        req_i   = req;
        gnt_i   = g;
        vld_i   = v;
        rdata_i = rd;
        for (int k = 0; k < N; k++) data_i[k*W +: W] = $urandom;
        if (!rst) begin
            rr_m = 0;
            idq.delete();
        end
        e.req = (req != 0) && (idq.size() < M);
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req[(rr_m + k) % N]) w = (rr_m + k) % N;
        end
        e.gnt  = '0;
        e.data = '0;
        if (e.req) e.data = data_i[w*W +: W];
        if (e.req && g) e.gnt[w] = 1'b1;
        e.vld  = '0;
        e.spur = 1'b0;
        if (v) begin
            if (idq.size() > 0) e.vld[idq[0]] = 1'b1;
            else e.spur = 1'b1;
        end
        e.rdata = rd;
        sb.push_back(e);
        if (rst) begin
            if (v && idq.size() > 0) void'(idq.pop_front());
            if (e.req && g) begin
                idq.push_back(w);
                rr_m = (w + 1) % N;
            end
        end
    endtask

    // Monitor: compares each predicted cycle away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("req_o", {31'b0, req_o}, {31'b0, e.req});
                chk("gnt_o", {28'b0, gnt_o}, {28'b0, e.gnt});
                chk("vld_o", {28'b0, vld_o}, {28'b0, e.vld});
                chk("spurious_o", {31'b0, spurious_o}, {31'b0, e.spur});
                chk("rdata_o", {31'b0, rdata_o == {N{e.rdata}}}, 32'd1);
                if (e.req) chk("data_o", data_o, e.data);
            end
        end
    end

    initial begin
        rst_ni  = 1'b0;
        req_i   = '0;
        gnt_i   = 1'b0;
        vld_i   = 1'b0;
        data_i  = '0;
        rdata_i = '0;
        // reset state
        step(4'b0000, 0, 0, 0, 32'h0);
        step(4'b0000, 0, 0, 0, 32'h0);
        step(4'b0000, 0, 0, 1, 32'h0);
        // spurious response right after reset
        step(4'b0000, 0, 1, 1, 32'hDEADBEEF);
        step(4'b0000, 0, 0, 1, 32'h0);
        // full contention, one-cycle bank latency
        step(4'b1111, 1, 0, 1, $urandom);
        for (int i = 0; i < 5; i++) step(4'b1111, 1, 1, 1, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        // full stall on master 2
        for (int i = 0; i < 4; i++) step(4'b0100, 1, 0, 1, $urandom);
        step(4'b0100, 1, 1, 1, $urandom);
        step(4'b0100, 0, 0, 1, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        // simultaneous push and pop
        step(4'b1000, 1, 0, 1, $urandom);
        step(4'b0010, 1, 1, 1, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        // bank backpressure
        for (int i = 0; i < 3; i++) step(4'b0011, 0, 0, 1, $urandom);
        step(4'b0011, 1, 0, 1, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        // reset with two transactions outstanding
        step(4'b0110, 1, 0, 1, $urandom);
        step(4'b0110, 1, 0, 1, $urandom);
        step(4'b0000, 0, 0, 0, $urandom);
        step(4'b0000, 0, 1, 1, $urandom);
        step(4'b1111, 1, 0, 1, $urandom);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(4'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 4),
                 ($urandom_range(0, 199) != 0), $urandom);
        end
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tcdm_varlat_bank_arb.md
TCDM_VARLAT_BANK_ARB -- requirements
Module: tcdm_varlat_bank_arb

Interface
REQ-001 SHALL have parameter NumIn, default 4, number of master ports (addr_dec_resp_mux_varlat instances) contending for this bank; legal range 1..32.
REQ-002 SHALL have parameter ReqDataWidth, default 32, width of the request payload (address/wdata/wen/be bundle), forwarded unmodified.
REQ-003 SHALL have parameter RespDataWidth, default 32, width of the read response.
REQ-004 SHALL have parameter MaxOutstanding, default 2, depth of the in-order ID queue; legal range 1..8.
REQ-005 SHALL have derived parameter LogNumIn = (NumIn > 1 ? $clog2(NumIn) : 1).
REQ-006 clk_i  input  1  clock; all state updates on the rising edge.
REQ-007 rst_ni  input  1  reset, asynchronous, active-low.
REQ-008 req_i  input  NumIn  per-master request from the upstream address decoders.
REQ-009 gnt_o  output  NumIn  per-master grant.
REQ-010 data_i  input  NumIn x ReqDataWidth  per-master request payload.
REQ-011 vld_o  output  NumIn  per-master response valid, one-hot or zero.
REQ-012 rdata_o  output  NumIn x RespDataWidth  response data, the same rdata_i broadcast to every master.
REQ-013 req_o  output  1  request to the bank.
REQ-014 gnt_i  input  1  bank accepts the request this cycle.
REQ-015 data_o  output  ReqDataWidth  payload of the selected master.
REQ-016 vld_i  input  1  bank response valid, arbitrary latency >= 1 cycle, in order.
REQ-017 rdata_i  input  RespDataWidth  bank response data.
REQ-018 spurious_o  output  1  single-cycle pulse: vld_i arrived with no transaction outstanding.

Function
REQ-019 Arbitration SHALL be round-robin. The winner is the first requesting index at or after the priority pointer rr_q, scanning upward modulo NumIn.
REQ-020 req_o SHALL equal |req_i AND (count_q < MaxOutstanding). The full check SHALL use only registered state, so there is no combinational path from vld_i to req_o or gnt_o.
REQ-021 gnt_o[w] SHALL be 1 only for the winner w, and only when req_o=1 and gnt_i=1; all other bits SHALL be 0.
REQ-022 data_o SHALL equal data_i[w] whenever req_o=1; when req_o=0, data_o is don't-care.
REQ-023 On a handshake (req_o and gnt_i), rr_q SHALL become (w+1) mod NumIn on the next edge. Otherwise rr_q SHALL hold.
REQ-024 On a handshake, index w SHALL be pushed into the ID FIFO (depth MaxOutstanding) and count_q incremented.
REQ-025 On vld_i=1 with count_q>0: vld_o[head] SHALL be 1 in the same cycle (combinational), the head SHALL be popped, and count_q decremented.
REQ-026 A simultaneous push and pop SHALL leave count_q unchanged, advance both read and write pointers, and deliver the response to the old head.
REQ-027 On vld_i=1 with count_q=0: all vld_o SHALL be 0, spurious_o SHALL be 1 for that cycle, and no state SHALL change.
REQ-028 FIFO pointers SHALL wrap modulo MaxOutstanding. count_q SHALL never exceed MaxOutstanding and never underflow.
REQ-029 When count_q=MaxOutstanding, req_o SHALL be 0 and no gnt_o bit SHALL be asserted, even if vld_i=1 in that same cycle; the freed slot is usable from the next cycle.
REQ-030 If gnt_i=0 while req_o=1, no state SHALL change, and the winner is re-evaluated the next cycle (requests are not locked).
REQ-031 With NumIn=1, there SHALL be no arbitration; the FIFO holds only occupancy, and vld_o[0]=vld_i AND (count_q>0).
REQ-032 rdata_o SHALL be combinational from rdata_i with no register stage.

Reset
REQ-033 While rst_ni=0, asynchronously: rr_q=0, count_q=0, FIFO read/write pointers=0, and FIFO contents cleared to 0.
REQ-034 During and immediately after reset: req_o=0 when req_i=0, gnt_o=0, vld_o=0, spurious_o=0.
REQ-035 Reset mid-transaction SHALL discard all outstanding IDs. A vld_i arriving after reset with count_q=0 SHALL be handled per REQ-027.

Verification (NumIn=4, MaxOutstanding=2 unless stated)
REQ-036 Contention: req_i=4'b1111, gnt_i=1 continuous, rr_q=0 after reset, bank returns vld_i 1 cycle later. Required: grants go to masters 0,1,2,3,0 on consecutive cycles, and vld_o is one-hot following the same order one cycle later.
REQ-037 Full stall: req_i=4'b0100, gnt_i=1, vld_i held 0. Required: 2 grants to master 2, then req_o=0 and count_q=2. A vld_i pulse then yields vld_o=4'b0100, and req_o returns to 1 on the following cycle.
REQ-038 Simultaneous push/pop: count_q=1 (head=3), master 1 granted in the same cycle as vld_i. Required: vld_o=4'b1000, count_q remains 1, and the next vld_i yields vld_o=4'b0010.
REQ-039 Spurious response: after reset, vld_i=1 with rdata_i=32'hDEADBEEF. Required: vld_o=0 and a one-cycle spurious_o=1.
REQ-040 Bank backpressure: req_i=4'b0011, gnt_i=0 for 3 cycles, then 1. Required: gnt_o=0 for 3 cycles, rr_q unchanged, then gnt_o=4'b0001.
REQ-041 Reset mid-flight: count_q=2, assert rst_ni=0 for 1 cycle. Required: count_q=0 and rr_q=0; a subsequent vld_i yields spurious_o=1 and vld_o=0.
